// File: rtl/incr_pattern_gen.sv
// Incrementing-pattern source with software-triggered bursts, programmable length and inter-word gap.
// Optional bit-0 error injection is enabled by defining INCR_PATTERN_GEN_ERR_INJECT_EN.
module incr_pattern_gen #(
  parameter int CNT_WIDTH = 8,
  parameter int LEN_WIDTH = 16,
  parameter int GAP_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic                 stop,
  input  logic [LEN_WIDTH-1:0] burst_len,
  input  logic [GAP_WIDTH-1:0] gap_cycles,
  input  logic                 data_ready,
`ifdef INCR_PATTERN_GEN_ERR_INJECT_EN
  input  logic                 inject_err,
`endif
  output logic [CNT_WIDTH-1:0] data_out,
  output logic                 data_valid,
  output logic                 busy,
  output logic                 done,
  output logic [31:0]          words_sent
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CNT_WIDTH-1:0] r_pat;
  logic [LEN_WIDTH-1:0] r_len;
  logic [LEN_WIDTH-1:0] r_word_cnt;
  logic [GAP_WIDTH-1:0] r_gap;
  logic [GAP_WIDTH-1:0] r_gap_cnt;
  logic                 r_stop_seen;
  logic [31:0]          r_words;

  logic w_accept;
  logic w_xfer;
  logic w_last;
  logic [LEN_WIDTH-1:0] w_word_nxt;

  assign data_valid = (r_state == S_RUN);
  assign busy       = (r_state == S_RUN) || (r_state == S_GAP);
  assign done       = (r_state == S_DONE);
  assign words_sent = r_words;

  assign w_accept   = (r_state == S_IDLE) && start && !stop;
  assign w_xfer     = data_valid && data_ready;
  assign w_word_nxt = r_word_cnt + LEN_WIDTH'(1);
  // A zero length means continuous, so the word counter only marks the end when a length was given.
  assign w_last     = (r_len != '0) && (w_word_nxt == r_len);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = S_RUN;
      S_RUN: begin
        if (w_xfer) begin
          if (w_last || stop || r_stop_seen) w_state_nxt = S_DONE;
          else if (r_gap != '0)              w_state_nxt = S_GAP;
          else                               w_state_nxt = S_RUN;
        end
      end
      S_GAP: begin
        if (stop)                         w_state_nxt = S_DONE;
        else if (r_gap_cnt <= GAP_WIDTH'(1)) w_state_nxt = S_RUN;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_len      <= '0;
      r_gap      <= '0;
      r_word_cnt <= '0;
    end else if (w_accept) begin
      r_len      <= burst_len;
      r_gap      <= gap_cycles;
      r_word_cnt <= '0;
    end else if (w_xfer) begin
      r_word_cnt <= w_word_nxt;
    end
  end

  // Pattern and transfer totals survive across bursts; only reset clears them.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pat   <= '0;
      r_words <= '0;
    end else if (w_xfer) begin
      r_pat   <= r_pat + CNT_WIDTH'(1);
      r_words <= r_words + 32'd1;
    end
  end

  // A stop arriving while a word waits is held until that word has gone.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                          r_stop_seen <= 1'b0;
    else if (w_accept)                  r_stop_seen <= 1'b0;
    else if ((r_state == S_RUN) && stop) r_stop_seen <= 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                  r_gap_cnt <= '0;
    else if (w_xfer)            r_gap_cnt <= r_gap;
    else if (r_state == S_GAP)  r_gap_cnt <= r_gap_cnt - GAP_WIDTH'(1);
  end

`ifdef INCR_PATTERN_GEN_ERR_INJECT_EN
  logic r_inj;

  // A new pulse wins over the clear so back-to-back requests are not lost.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)           r_inj <= 1'b0;
    else if (inject_err) r_inj <= 1'b1;
    else if (w_xfer)     r_inj <= 1'b0;
  end

  assign data_out = r_pat ^ {{(CNT_WIDTH-1){1'b0}}, r_inj & data_valid};
`else
  assign data_out = r_pat;
`endif

endmodule

// File: doc/incr_pattern_gen.md
Name: incr_pattern_gen

Overview:
- Source stage directly upstream of the increment-pattern checker. It produces an incrementing data stream with a valid/ready handshake.
- Bursts are software-triggered, with a programmable length and an inter-word gap, so the link under test can be exercised at full rate or throttled.
- The pattern counter persists across bursts, so a checker downstream sees a continuous increment sequence. Only reset clears it.

Parameters:
- CNT_WIDTH, 8, width of data_out and of the pattern counter.
- LEN_WIDTH, 16, width of burst_len and of the internal word counter.
- GAP_WIDTH, 8, width of gap_cycles.

Ports:
- clk  input  1  single clock; all logic on posedge.
- rstn  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to begin a burst; sampled only in IDLE.
- stop  input  1  request to end the current burst early.
- burst_len  input  LEN_WIDTH  words per burst, latched on an accepted start; 0 = continuous until stop.
- gap_cycles  input  GAP_WIDTH  idle cycles after each transfer, latched on an accepted start; 0 = back-to-back.
- data_ready  input  1  downstream can accept data.
- data_out  output  CNT_WIDTH  pattern word.
- data_valid  output  1  data_out is valid.
- busy  output  1  high in RUN or GAP.
- done  output  1  one-cycle pulse when a burst ends.
- words_sent  output  32  total transfers since reset; wraps at 2^32.

Behaviour:
- Reset (async, rstn low): data_out=0, data_valid=0, busy=0, done=0, words_sent=0, pattern counter=0, FSM=IDLE. Mid-burst reset aborts immediately with no done pulse.
- Transfer: occurs on any cycle where data_valid && data_ready.
- Stability: while data_valid && !data_ready, data_out and data_valid hold stable.
- Per transfer: pattern counter increments, wrapping 2^CNT_WIDTH-1 -> 0; words_sent increments; the internal burst counter increments.
- IDLE:
  - data_valid=0, busy=0.
  - start=1 and stop=0: latch burst_len and gap_cycles, clear the burst counter, go to RUN. data_valid rises the next cycle, with data_out = current pattern counter.
  - start and stop both high: stop wins; stay in IDLE.
- RUN:
  - data_valid=1, data_out = pattern counter.
  - On a transfer, check in this priority order:
    1. Last word of the burst (burst_len != 0 and burst counter+1 == burst_len), or stop seen: go to DONE.
    2. Else, gap_cycles != 0: go to GAP, load the gap counter.
    3. Else, stay in RUN and present the next word the following cycle (1 word/cycle at full rate).
  - stop while a word is presented but not accepted: recorded, not acted on. The presented word is never withdrawn; the block ends after that word transfers.
- GAP:
  - data_valid=0.
  - Counts gap_cycles cycles, then returns to RUN.
  - stop in GAP: go directly to DONE.
- DONE:
  - One cycle; done=1, data_valid=0, busy=0; then IDLE.
- start outside IDLE: ignored.
- burst_len=0: the burst runs until stop; the word counter wraps silently.
- Latency: start at cycle N -> first data_valid at N+1. The last transfer at cycle M gives done at M+1.

Optional Feature:
- Macro: INCR_PATTERN_GEN_ERR_INJECT_EN.
- With the macro defined:
  - Extra input inject_err (1 bit).
  - A pulse arms a one-shot flag. The next word presented has bit 0 inverted in data_out; the flag clears on that word's transfer.
  - The pattern counter is unaffected, so the following word is correct again.
  - Reset clears the flag.
- Without the macro: no port; data_out is always the unmodified pattern counter.

Test Plan:
- Reset, then start with burst_len=4, gap=0, data_ready=1 -> data_out 0,1,2,3 on 4 consecutive cycles; done at cycle 5; words_sent=4.
- Second start with burst_len=3 -> data_out 4,5,6; pattern continuity across bursts; words_sent=7.
- burst_len=3, gap=2, data_ready=1 -> valid pattern 1,0,0,1,0,0,1, then done.
- data_ready held low 5 cycles during a word -> data_out/data_valid stable for all 5 cycles; no increment.
- CNT_WIDTH=8, 300-word burst -> data_out wraps 255 -> 0.
- Continuous burst (burst_len=0), stop raised while valid and !ready -> the current word completes on ready, done pulses, no further valid.
- Start and stop in the same IDLE cycle -> no valid, no done.
- With INCR_PATTERN_GEN_ERR_INJECT_EN, pulse inject_err before word 10 -> word 10 sent as 11 (bit 0 flipped); word 11 sent as 11; the downstream checker's err_count increments.
